// File: rtl/full_dummy_project_top.sv
// rtl/full_dummy_project_top.sv - per-BX adder: reads two input memories, writes their sum to an output memory
//
// Purpose: on each new bunch crossing (BX) reads N = min(nent1, nent2, 16) entries
// from two input memories, adds them pairwise and writes the sums to the output memory
// at the same {page, index}; the page is bit 0 of the BX number.
//
// Ports:
//   clk, reset                     clock (rising edge), synchronous active-high reset
//   en_proc                        processing enable; gates the start of a new BX
//   bx_in / bx_out                 current BX number / BX number of last completed BX
//   memX_readaddr, memX_enb        input-memory read address {page, index} and enable
//   memX_nent, memX_dout           input-memory entry count and read data (2-cycle latency)
//   memout_ena, memout_wea         output-memory port enable and write enable
//   memout_writeaddr, memout_din   output-memory write address {page, index} and data
module full_dummy_project_top (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_proc,
  input  logic [1:0]  bx_in,
  output logic [1:0]  bx_out,
  output logic [4:0]  mem1_readaddr,
  output logic [4:0]  mem2_readaddr,
  output logic        mem1_enb,
  output logic        mem2_enb,
  input  logic [4:0]  mem1_nent,
  input  logic [4:0]  mem2_nent,
  input  logic [31:0] mem1_dout,
  input  logic [31:0] mem2_dout,
  output logic        memout_ena,
  output logic        memout_wea,
  output logic [4:0]  memout_writeaddr,
  output logic [31:0] memout_din
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_first_bx;
  logic [1:0]  r_last_bx;
  logic [1:0]  r_bx_cur;
  logic [1:0]  r_bx_out;
  logic        r_page;
  logic [4:0]  r_n;
  logic [3:0]  r_i;
  logic [4:0]  r_last_addr;
  // Read-valid / index pipeline, aligned with the 2-cycle memory read latency.
  logic        r_v1;
  logic        r_v2;
  logic [3:0]  r_idx1;
  logic [3:0]  r_idx2;

  logic [4:0]  w_min;
  logic [4:0]  w_n_sat;
  logic        w_start;
  logic        w_last_read;
  logic        w_rd_en;

  assign w_min       = (mem1_nent < mem2_nent) ? mem1_nent : mem2_nent;
  assign w_n_sat     = (w_min > 5'd16) ? 5'd16 : w_min;
  assign w_start     = (r_state == S_IDLE) && en_proc && (r_first_bx || (bx_in != r_last_bx));
  assign w_last_read = ({1'b0, r_i} == (r_n - 5'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = (w_n_sat == 5'd0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        w_rd_en = 1'b1;
        if (w_last_read) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Wait until the final read's data has been written out.
        if (!(r_v1 || r_v2)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_first_bx  <= 1'b1;
      r_last_bx   <= 2'd0;
      r_bx_cur    <= 2'd0;
      r_bx_out    <= 2'd0;
      r_page      <= 1'b0;
      r_n         <= 5'd0;
      r_i         <= 4'd0;
      r_last_addr <= 5'd0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_idx1      <= 4'd0;
      r_idx2      <= 4'd0;
    end else begin
      if (w_start) begin
        r_first_bx <= 1'b0;
        r_last_bx  <= bx_in;
        r_bx_cur   <= bx_in;
        r_page     <= bx_in[0];
        r_n        <= w_n_sat;
        r_i        <= 4'd0;
      end
      if (w_rd_en) begin
        r_i         <= r_i + 4'd1;
        r_last_addr <= {r_page, r_i};
      end
      r_v1   <= w_rd_en;
      r_idx1 <= r_i;
      r_v2   <= r_v1;
      r_idx2 <= r_idx1;
      if (r_state == S_DONE) begin
        r_bx_out <= r_bx_cur;
      end
    end
  end

  // Read address is live while reading and otherwise holds the last issued address.
  assign mem1_enb         = w_rd_en;
  assign mem2_enb         = w_rd_en;
  assign mem1_readaddr    = w_rd_en ? {r_page, r_i} : r_last_addr;
  assign mem2_readaddr    = w_rd_en ? {r_page, r_i} : r_last_addr;

  assign memout_ena       = r_v2;
  assign memout_wea       = r_v2;
  assign memout_writeaddr = {r_page, r_idx2};
  assign memout_din       = r_v2 ? (mem1_dout + mem2_dout) : 32'd0;

  assign bx_out           = r_bx_out;

endmodule

// File: tb/tb_full_dummy_project_top.sv
// tb/tb_full_dummy_project_top.sv - directed self-checking bench for full_dummy_project_top
module tb_full_dummy_project_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_proc;
  logic [1:0]  bx_in;
  logic [1:0]  bx_out;
  logic [4:0]  mem1_readaddr, mem2_readaddr;
  logic        mem1_enb, mem2_enb;
  logic [4:0]  mem1_nent, mem2_nent;
  logic [31:0] mem1_dout, mem2_dout;
  logic        memout_ena, memout_wea;
  logic [4:0]  memout_writeaddr;
  logic [31:0] memout_din;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] m1 [0:31];
  logic [31:0] m2 [0:31];
  logic [31:0] m1_d1, m2_d1;

  int          rd_addr_q[$];
  int          rd_cyc_q[$];
  bit          rd_ok_q[$];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  bit          wr_ok_q[$];

  full_dummy_project_top dut (
    .clk(clk), .reset(reset), .en_proc(en_proc), .bx_in(bx_in), .bx_out(bx_out),
    .mem1_readaddr(mem1_readaddr), .mem2_readaddr(mem2_readaddr),
    .mem1_enb(mem1_enb), .mem2_enb(mem2_enb),
    .mem1_nent(mem1_nent), .mem2_nent(mem2_nent),
    .mem1_dout(mem1_dout), .mem2_dout(mem2_dout),
    .memout_ena(memout_ena), .memout_wea(memout_wea),
    .memout_writeaddr(memout_writeaddr), .memout_din(memout_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Input memories: data appears two cycles after the address is presented with enb.
  always @(posedge clk) begin
    if (mem1_enb) m1_d1 <= m1[mem1_readaddr];
    if (mem2_enb) m2_d1 <= m2[mem2_readaddr];
    mem1_dout <= m1_d1;
    mem2_dout <= m2_d1;
  end

  always @(negedge clk) begin
    if (mem1_enb || mem2_enb) begin
      rd_addr_q.push_back(int'(mem1_readaddr));
      rd_cyc_q.push_back(cyc);
      rd_ok_q.push_back(mem1_enb && mem2_enb && (mem1_readaddr == mem2_readaddr));
    end
    if (memout_ena || memout_wea) begin
      wr_addr_q.push_back(int'(memout_writeaddr));
      wr_data_q.push_back(memout_din);
      wr_cyc_q.push_back(cyc);
      wr_ok_q.push_back(memout_ena && memout_wea);
    end
  end

  task automatic clear_log();
    rd_addr_q.delete(); rd_cyc_q.delete(); rd_ok_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); wr_ok_q.delete();
  endtask

  task automatic drive_bx(input logic [1:0] bx, input logic [4:0] n1, input logic [4:0] n2);
    @(posedge clk); #1;
    mem1_nent = n1; mem2_nent = n2; bx_in = bx; en_proc = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en_proc = 1'b0; bx_in = 2'd0; mem1_nent = 5'd0; mem2_nent = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bx_out !== 2'd0) begin errors++; $display("FAIL reset_bx_out: got %0d want 0", bx_out); end
    checks++;
    if ({mem1_enb, mem2_enb, memout_ena, memout_wea} !== 4'b0) begin
      errors++; $display("FAIL reset_enables: got %b want 0000", {mem1_enb, mem2_enb, memout_ena, memout_wea});
    end
    checks++;
    if ({mem1_readaddr, mem2_readaddr, memout_writeaddr} !== 15'd0) begin
      errors++; $display("FAIL reset_addrs: got %h/%h/%h want 0", mem1_readaddr, mem2_readaddr, memout_writeaddr);
    end
    checks++;
    if (memout_din !== 32'd0) begin errors++; $display("FAIL reset_din: got %h want 0", memout_din); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 32; k++) begin m1[k] = 32'd5; m2[k] = 32'd7; end
    clear_log();
    drive_bx(2'd2, 5'd5, 5'd5);
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_addr_q.size() != 5 || wr_addr_q.size() != 5) begin
      errors++; $display("FAIL basic_count: reads %0d writes %0d want 5/5", rd_addr_q.size(), wr_addr_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (rd_addr_q[k] != k || rd_cyc_q[k] != rd_cyc_q[0] + k || !rd_ok_q[k] ||
            wr_addr_q[k] != k || wr_data_q[k] !== 32'h0000000C || wr_cyc_q[k] != rd_cyc_q[k] + 2 || !wr_ok_q[k]) begin
          errors++;
          $display("FAIL basic_beat%0d: rd a=%0d c=%0d wr a=%0d d=%h c=%0d want a=%0d d=0000000c wrc=rdc+2",
                   k, rd_addr_q[k], rd_cyc_q[k], wr_addr_q[k], wr_data_q[k], wr_cyc_q[k], k);
        end
      end
    end
    checks++;
    if (bx_out !== 2'd2) begin errors++; $display("FAIL basic_bx_out: got %0d want 2", bx_out); end
  endtask

  task automatic test_page1();
    for (int k = 0; k < 32; k++) begin m1[k] = k * 3 + 1; m2[k] = 32'h100 * k; end
    clear_log();
    drive_bx(2'd3, 5'd16, 5'd9);
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_addr_q.size() != 9 || wr_addr_q.size() != 9) begin
      errors++; $display("FAIL page1_count: reads %0d writes %0d want 9/9", rd_addr_q.size(), wr_addr_q.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (rd_addr_q[k] != 16 + k || wr_addr_q[k] != 16 + k || wr_data_q[k] !== m1[16 + k] + m2[16 + k] ||
            wr_cyc_q[k] != wr_cyc_q[0] + k || wr_cyc_q[k] != rd_cyc_q[k] + 2) begin
          errors++;
          $display("FAIL page1_beat%0d: rd a=%0d wr a=%0d d=%h want a=%0d d=%h", k, rd_addr_q[k],
                   wr_addr_q[k], wr_data_q[k], 16 + k, m1[16 + k] + m2[16 + k]);
        end
      end
    end
    checks++;
    if (bx_out !== 2'd3) begin errors++; $display("FAIL page1_bx_out: got %0d want 3", bx_out); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 32; k++) begin m1[k] = 32'hFFFFFFFF; m2[k] = 32'd1; end
    clear_log();
    drive_bx(2'd0, 5'd3, 5'd3);
    repeat (30) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 3) begin
      errors++; $display("FAIL wrap_count: writes %0d want 3", wr_addr_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (wr_data_q[k] !== 32'h00000000 || wr_addr_q[k] != k) begin
          errors++; $display("FAIL wrap_beat%0d: a=%0d d=%h want a=%0d d=00000000", k, wr_addr_q[k], wr_data_q[k], k);
        end
      end
    end
    checks++;
    if (bx_out !== 2'd0) begin errors++; $display("FAIL wrap_bx_out: got %0d want 0", bx_out); end
  endtask

  task automatic test_zero_entries();
    clear_log();
    drive_bx(2'd1, 5'd0, 5'd5);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_addr_q.size() != 0 || wr_addr_q.size() != 0) begin
      errors++; $display("FAIL zero_activity: reads %0d writes %0d want 0/0", rd_addr_q.size(), wr_addr_q.size());
    end
    checks++;
    if (bx_out !== 2'd1) begin errors++; $display("FAIL zero_bx_out: got %0d want 1", bx_out); end
  endtask

  task automatic test_hold_and_saturate();
    clear_log();
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_addr_q.size() != 0) begin errors++; $display("FAIL hold_no_restart: reads %0d want 0", rd_addr_q.size()); end
    for (int k = 0; k < 32; k++) begin m1[k] = 32'h01000000 * k; m2[k] = 32'hA5A50000 ^ k; end
    drive_bx(2'd2, 5'd20, 5'd31);
    repeat (45) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_addr_q.size() != 16 || wr_addr_q.size() != 16) begin
      errors++; $display("FAIL sat_count: reads %0d writes %0d want 16/16", rd_addr_q.size(), wr_addr_q.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (rd_addr_q[k] != k || wr_addr_q[k] != k || wr_data_q[k] !== m1[k] + m2[k] ||
            wr_cyc_q[k] != wr_cyc_q[0] + k) begin
          errors++; $display("FAIL sat_beat%0d: a=%0d d=%h want a=%0d d=%h", k, wr_addr_q[k], wr_data_q[k], k, m1[k] + m2[k]);
        end
      end
    end
    checks++;
    if (bx_out !== 2'd2) begin errors++; $display("FAIL sat_bx_out: got %0d want 2", bx_out); end
  endtask

  task automatic test_en_drop();
    clear_log();
    drive_bx(2'd3, 5'd6, 5'd6);
    repeat (2) @(posedge clk);
    #1 en_proc = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 6) begin
      errors++; $display("FAIL endrop_count: writes %0d want 6", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] != 16 || wr_addr_q[5] != 21) begin
        errors++; $display("FAIL endrop_addrs: first %0d last %0d want 16/21", wr_addr_q[0], wr_addr_q[5]);
      end
    end
    checks++;
    if (bx_out !== 2'd3) begin errors++; $display("FAIL endrop_bx_out: got %0d want 3", bx_out); end
    clear_log();
    @(posedge clk); #1 bx_in = 2'd0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_addr_q.size() != 0 || bx_out !== 2'd3) begin
      errors++; $display("FAIL endrop_no_start: reads %0d bx_out %0d want 0/3", rd_addr_q.size(), bx_out);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    drive_bx(2'd1, 5'd16, 5'd16);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1; bx_in = 2'd2;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({memout_ena, memout_wea, mem1_enb, mem2_enb} !== 4'b0 || bx_out !== 2'd0) begin
      errors++; $display("FAIL midreset_outputs: en=%b bx_out=%0d want 0000/0",
                         {memout_ena, memout_wea, mem1_enb, mem2_enb}, bx_out);
    end
    clear_log();
    @(posedge clk); #1 reset = 1'b0;
    checks++;
    if (wr_addr_q.size() != 0) begin errors++; $display("FAIL midreset_writes: got %0d want 0", wr_addr_q.size()); end
    repeat (45) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 16) begin
      errors++; $display("FAIL midreset_restart: writes %0d want 16", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] != 0 || wr_addr_q[15] != 15 || wr_data_q[15] !== m1[15] + m2[15]) begin
        errors++; $display("FAIL midreset_data: a0=%0d a15=%0d d15=%h want 0/15/%h",
                           wr_addr_q[0], wr_addr_q[15], wr_data_q[15], m1[15] + m2[15]);
      end
    end
    checks++;
    if (bx_out !== 2'd2) begin errors++; $display("FAIL midreset_bx_out: got %0d want 2", bx_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_page1();
    test_wrap();
    test_zero_entries();
    test_hold_and_saturate();
    test_en_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/full_dummy_project_top.md
FULL_DUMMY_PROJECT_TOP -- requirements
Module: full_dummy_project_top

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: en_proc  in  1  processing enable; a new BX is started only while high.
REQ-004 SHALL have port: bx_in  in  2  current bunch-crossing number from the BX driver.
REQ-005 SHALL have port: bx_out  out  2  BX number of the most recently completed BX.
REQ-006 SHALL have ports: mem1_readaddr / mem2_readaddr  out  5  read address {page, index[3:0]}.
REQ-007 SHALL have ports: mem1_enb / mem2_enb  out  1  input-memory read enable.
REQ-008 SHALL have ports: mem1_nent / mem2_nent  in  5  entry count of the input memory.
REQ-009 SHALL have ports: mem1_dout / mem2_dout  in  32  input-memory read data, valid 2 cycles after the address is presented with enb=1.
REQ-010 SHALL have port: memout_ena  out  1  output-memory port-A enable.
REQ-011 SHALL have port: memout_wea  out  1  output-memory write enable.
REQ-012 SHALL have port: memout_writeaddr  out  5  write address {page, index[3:0]}.
REQ-013 SHALL have port: memout_din  out  32  write data.

Function
REQ-014 SHALL implement an FSM with states IDLE, READ, DRAIN, DONE.
REQ-015 SHALL hold the last started BX in last_bx, plus a flag first_bx, which reset sets to 1.
REQ-016 SHALL start a BX in IDLE when en_proc=1 and either first_bx=1 or bx_in!=last_bx.
REQ-017 On start, SHALL latch bx_cur=bx_in, page=bx_in[0], N=min(mem1_nent,mem2_nent) saturated to 16, and clear first_bx.
REQ-018 On start with N=0, SHALL go directly to DONE; otherwise SHALL go to READ with index i=0.
REQ-019 In READ, each cycle SHALL drive mem1_enb=mem2_enb=1 and both readaddr={page,i[3:0]}, then increment i.
REQ-020 In READ, after issuing i=N-1, SHALL go to DRAIN.
REQ-021 SHALL delay the read-valid flag and index through a 2-stage pipeline to align with dout.
REQ-022 When the delayed valid is 1, SHALL drive memout_ena=memout_wea=1 in that cycle.
REQ-023 In that same cycle, SHALL drive memout_writeaddr={page,delayed index} and memout_din=mem1_dout+mem2_dout, modulo 2^32 with carry discarded.
REQ-024 In DRAIN, SHALL remain until the pipeline is empty, then go to DONE.
REQ-025 In DONE, SHALL set bx_out<=bx_cur for one cycle, then return to IDLE.
REQ-026 Outside READ, mem*_enb SHALL be 0 and readaddr SHALL hold its last value.
REQ-027 When no write is pending, memout_ena and memout_wea SHALL be 0.
REQ-028 A bx_in change during READ/DRAIN/DONE SHALL NOT abort the current BX; the newer bx_in SHALL be picked up in IDLE by the last_bx compare (intermediate values may be skipped).
REQ-029 en_proc falling mid-BX SHALL let the current BX finish; no new start SHALL occur while en_proc=0.
REQ-030 Exactly N writes SHALL be issued per BX, at consecutive indices 0..N-1, in consecutive cycles.

Reset
REQ-031 While reset=1, SHALL set FSM=IDLE, i=0, the pipeline to invalid, and first_bx=1.
REQ-032 While reset=1, SHALL set bx_out=0, all enables=0, all addresses=0, and memout_din=0.
REQ-033 Reset asserted mid-BX SHALL abandon the BX with no further writes; the next start SHALL occur on the first en_proc=1 cycle after reset releases.

Verification
REQ-034 Memories filled with 5 and 7, nent=5, bx_in=2, en_proc rising -> reads at addr 0..4; five writes of 0x0000000C to addr 0..4, each 2 cycles after its read; bx_out=2.
REQ-035 bx_in=3, nent1=16, nent2=9 -> N=9; reads/writes at addr 16..24 (page 1); bx_out=3.
REQ-036 mem1=0xFFFFFFFF, mem2=1 -> memout_din=0x00000000 (wrap).
REQ-037 nent1=0 -> no enb pulse and no write; bx_out updates to bx_in.
REQ-038 Reset pulse during READ -> memout_wea=0 from the next cycle; bx_out=0; processing restarts after release.
REQ-039 bx_in held constant after completion -> no second start; bx_in increments -> new BX starts from IDLE.
